// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: buffers a host byte stream and paces it into the DES S-box hash core, then returns the digest
module hash_msg_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int BYTE_GAP   = 5,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_start,
    input  logic [63:0] msg_len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        M_valid,
    output logic [7:0]  message,
    output logic [63:0] counter,
    input  logic [31:0] digest_in,
    input  logic        hash_ready_in,
    output logic [31:0] digest,
    output logic        digest_valid,
    output logic        busy,
    output logic        len_err,
    output logic        timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = $clog2(BYTE_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT_DIG} state_t;
    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   fifo_cnt;
    logic [63:0]     recv_cnt, sent_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   wait_cnt;
    logic            push, pop;
    assign in_ready = busy && (fifo_cnt < CW'(FIFO_DEPTH)) && (recv_cnt < counter);
    assign push     = in_valid && in_ready;
    assign pop      = (state == SEND) && (fifo_cnt != '0);
    // byte storage; occupancy is tracked by fifo_cnt so the array itself needs no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
    // FIFO bookkeeping plus the SEND/GAP/WAIT_DIG sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            recv_cnt     <= '0;
            sent_cnt     <= '0;
            gap_cnt      <= '0;
            wait_cnt     <= '0;
            M_valid      <= 1'b0;
            message      <= '0;
            counter      <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            len_err      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            M_valid      <= 1'b0;
            digest_valid <= 1'b0;
            len_err      <= 1'b0;
            timeout      <= 1'b0;
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                recv_cnt <= recv_cnt + 64'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            case (state)
                IDLE: begin
                    if (msg_start && msg_len == '0) begin
                        len_err <= 1'b1;
                    end else if (msg_start) begin
                        state    <= SEND;
                        counter  <= msg_len;
                        busy     <= 1'b1;
                        recv_cnt <= '0;
                        sent_cnt <= '0;
                    end
                end
                SEND: begin
                    if (pop) begin
                        message  <= mem[rd_ptr];
                        M_valid  <= 1'b1;
                        sent_cnt <= sent_cnt + 64'd1;
                        if (sent_cnt + 64'd1 == counter) begin
                            state    <= WAIT_DIG;
                            wait_cnt <= '0;
                        end else if (BYTE_GAP > 1) begin
                            state   <= GAP;
                            gap_cnt <= GW'(BYTE_GAP - 1);
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(1)) state <= SEND;
                    else gap_cnt <= gap_cnt - GW'(1);
                end
                WAIT_DIG: begin
                    if (hash_ready_in) begin
                        digest       <= digest_in;
                        digest_valid <= 1'b1;
                        busy         <= 1'b0;
                        counter      <= '0;
                        state        <= IDLE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb_hash_msg_feeder: directed checks of byte pacing, flow control, digest return, timeout and reset
module tb_hash_msg_feeder;
    logic        clk = 0, rst = 1, msg_start = 0, in_valid = 0, hash_ready_in = 0;
    logic [63:0] msg_len = 0;
    logic [7:0]  in_data = 0;
    logic [31:0] digest_in = 0;
    logic        in_ready, M_valid, digest_valid, busy, len_err, timeout;
    logic [7:0]  message;
    logic [63:0] counter;
    logic [31:0] digest;
    int n_checks = 0, n_errors = 0;
    int cyc = 0, dv_cnt = 0, to_cnt = 0, to_cyc = 0, stalls = 0;
    logic [7:0] mq [$];
    int         mc [$];
    logic [7:0] tx [0:7];

    hash_msg_feeder #(.FIFO_DEPTH(4), .BYTE_GAP(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .msg_start(msg_start), .msg_len(msg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .M_valid(M_valid), .message(message), .counter(counter),
        .digest_in(digest_in), .hash_ready_in(hash_ready_in),
        .digest(digest), .digest_valid(digest_valid), .busy(busy),
        .len_err(len_err), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // record strobes and pulses away from the active edge
    always @(negedge clk) begin
        if (M_valid) begin
            mq.push_back(message);
            mc.push_back(cyc);
        end
        if (digest_valid) dv_cnt++;
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] len);
        msg_start = 1;
        msg_len = len;
        tick();
        msg_start = 0;
    endtask

    task automatic push_range(input int lo, input int hi);
        int t;
        logic ok;
        for (int i = lo; i < hi; i++) begin
            in_valid = 1;
            in_data = tx[i];
            ok = 0;
            t = 0;
            while (!ok && t < 100) begin
                @(negedge clk);
                ok = in_ready;
                if (!ok) stalls++;
                tick();
                t++;
            end
            if (!ok) check("push_timeout", 0, 1);
        end
        in_valid = 0;
    endtask

    task automatic wait_mv(input int n);
        int t = 0;
        while (mq.size() < n && t < 300) begin
            tick();
            t++;
        end
        check("mv_count", mq.size(), n);
    endtask

    task automatic finish_digest(input logic [31:0] d);
        digest_in = d;
        hash_ready_in = 1;
        tick();
        hash_ready_in = 0;
        check("digest_valid", digest_valid, 1);
        check("digest", digest, d);
        check("busy_done", busy, 0);
        check("counter_clr", counter, 0);
        tick();
        check("dv_pulse", digest_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int dv0, to0;
        repeat (3) tick();
        check("rst_ctrl", {M_valid, digest_valid, busy, len_err, timeout, in_ready}, 0);
        check("rst_data", {message, digest}, 0);
        check("rst_cnt", counter, 0);
        rst = 0;
        tick();

        // "abc" with in_valid held
        mq.delete(); mc.delete();
        tx[0] = 8'h61; tx[1] = 8'h62; tx[2] = 8'h63;
        start(3);
        check("abc_busy", busy, 1);
        check("abc_counter", counter, 3);
        push_range(0, 3);
        check("abc_ready_done", in_ready, 0);
        wait_mv(3);
        check("abc_b0", mq[0], 8'h61);
        check("abc_b1", mq[1], 8'h62);
        check("abc_b2", mq[2], 8'h63);
        check("abc_gap0", mc[1] - mc[0], 5);
        check("abc_gap1", mc[2] - mc[1], 5);
        check("abc_counter_held", counter, 3);
        finish_digest(32'hDEADBEEF);

        // zero-length message
        mq.delete(); mc.delete();
        start(0);
        check("len_err_hi", len_err, 1);
        check("len_err_busy", busy, 0);
        tick();
        check("len_err_lo", len_err, 0);
        repeat (5) tick();
        check("len_err_no_mv", mq.size(), 0);

        // 8 bytes through a 4-entry buffer
        mq.delete(); mc.delete();
        for (int i = 0; i < 8; i++) tx[i] = 8'h10 + 8'(i);
        stalls = 0;
        start(8);
        push_range(0, 8);
        check("full_stall_seen", stalls > 0, 1);
        check("ready_after_8", in_ready, 0);
        wait_mv(8);
        for (int i = 0; i < 8; i++) check("order", mq[i], 8'h10 + 8'(i));
        for (int i = 1; i < 8; i++) check("pace8", mc[i] - mc[i-1], 5);
        finish_digest(32'h0BADF00D);

        // host stall with a stray hash_ready_in during SEND
        mq.delete(); mc.delete();
        tx[0] = 8'hA1; tx[1] = 8'hB2;
        start(2);
        push_range(0, 1);
        dv0 = dv_cnt;
        for (int i = 0; i < 20; i++) begin
            digest_in = 32'h11111111;
            hash_ready_in = (i == 10);
            tick();
        end
        hash_ready_in = 0;
        check("stall_mv_count", mq.size(), 1);
        check("stall_no_dv", dv_cnt - dv0, 0);
        check("stall_busy", busy, 1);
        push_range(1, 2);
        wait_mv(2);
        check("stall_b1", mq[1], 8'hB2);
        check("stall_spacing", mc[1] - mc[0] > 20, 1);
        finish_digest(32'hCAFEF00D);

        // digest never arrives
        mq.delete(); mc.delete();
        tx[0] = 8'h77;
        to0 = to_cnt;
        start(1);
        push_range(0, 1);
        wait_mv(1);
        t = 0;
        while (to_cnt == to0 && t < 100) begin
            tick();
            t++;
        end
        check("to_pulses", to_cnt - to0, 1);
        check("to_delay", to_cyc - mc[0], 16);
        check("to_busy", busy, 0);
        check("to_digest_kept", digest, 32'hCAFEF00D);
        check("to_counter", counter, 0);
        tick();
        check("to_pulse_lo", timeout, 0);

        // reset mid-message, then a clean 1-byte message
        for (int i = 0; i < 5; i++) tx[i] = 8'h30 + 8'(i);
        start(5);
        push_range(0, 2);
        rst = 1;
        tick();
        check("mid_rst_ctrl", {M_valid, digest_valid, busy, len_err, timeout, in_ready}, 0);
        check("mid_rst_data", {message, digest}, 0);
        check("mid_rst_cnt", counter, 0);
        rst = 0;
        tick();
        mq.delete(); mc.delete();
        tx[0] = 8'h5A;
        start(1);
        check("post_rst_counter", counter, 1);
        push_range(0, 1);
        wait_mv(1);
        check("post_rst_byte", mq[0], 8'h5A);
        finish_digest(32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
